// File: rtl/mem_bus_responder_if.sv
// CPU external bus bundle: address, write data, read data, request strobes, ready.
// Latency: none, wires only.
// Backpressure: the target holds ready until the master drops read/write (four-phase).
//   master: drives address, data_in, read, write; observes data_out, ready
//   slave : the responder side of the same signals
interface mem_bus_responder_if;
    logic [7:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic       ready;

    modport master (
        output address, data_in, read, write,
        input  data_out, ready
    );

    modport slave (
        input  address, data_in, read, write,
        output data_out, ready
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Bus target: RAM below IO_BASE plus port_out / port_in / timer registers above it.
// Latency: request sampled at edge N -> ready high after edge N+1+WAIT_CYCLES.
// Backpressure: ready is held until read and write are both sampled low; then one idle cycle.
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : address, data_in, read, write in; data_out, ready out
//   port_in, port_out : external input port, output port register
//   proto_err         : sticky, set when a request arrives with read and write both high
module mem_bus_responder #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  IO_BASE     = 8'hF0
) (
    input  logic                       clk,
    input  logic                       reset,
    mem_bus_responder_if.slave         bus,
    input  logic [7:0]                 port_in,
    output logic [7:0]                 port_out,
    output logic                       proto_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] wait_cnt;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       req_wr;
    logic [7:0] req_timer;   // timer value at the accepting edge
    logic [7:0] timer;
    logic [7:0] data_out_q;
    logic       ready_q;

    logic [7:0] ram [0:255];

    logic       is_ram;
    logic [7:0] io_off;
    logic       commit;
    logic [7:0] rd_val;

    assign bus.data_out = data_out_q;
    assign bus.ready    = ready_q;

    assign is_ram = (req_addr < IO_BASE);
    assign io_off = req_addr - IO_BASE;
    // The access happens on the edge that moves WAIT -> RESP.
    assign commit = (state == S_WAIT) && (wait_cnt == 4'd0);

    always_comb begin
        rd_val = 8'h00;
        if (is_ram) begin
            rd_val = ram[req_addr];
        end else begin
            case (io_off)
                8'd0:    rd_val = port_out;
                8'd1:    rd_val = port_in;
                8'd2:    rd_val = req_timer;
                default: rd_val = 8'h00;
            endcase
        end
    end

    // RAM contents survive reset; a store aborted by reset never reaches commit.
    always_ff @(posedge clk) begin
        if (!reset && commit && req_wr && is_ram) begin
            ram[req_addr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            req_addr   <= 8'h00;
            req_data   <= 8'h00;
            req_wr     <= 1'b0;
            req_timer  <= 8'h00;
            timer      <= 8'h00;
            data_out_q <= 8'h00;
            ready_q    <= 1'b0;
            port_out   <= 8'h00;
            proto_err  <= 1'b0;
        end else begin
            timer <= timer + 8'd1;
            case (state)
                S_IDLE: begin
                    if (bus.read || bus.write) begin
                        req_addr  <= bus.address;
                        req_data  <= bus.data_in;
                        // read+write together is serviced as a read
                        req_wr    <= bus.write && !bus.read;
                        req_timer <= timer;
                        wait_cnt  <= WAIT_INIT;
                        // Even with WAIT_CYCLES=0 one cycle is spent here so that
                        // the access lands on a single registered edge.
                        state     <= S_WAIT;
                        if (bus.read && bus.write) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= S_RESP;
                        ready_q <= 1'b1;
                        if (req_wr) begin
                            if (!is_ram) begin
                                case (io_off)
                                    8'd0:    port_out <= req_data;
                                    8'd2:    timer    <= req_data;  // overrides the increment
                                    default: ;
                                endcase
                            end
                        end else begin
                            data_out_q <= rd_val;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (!bus.read && !bus.write) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: two targets (WAIT_CYCLES=1 and 3) on one shared CPU bus.
// Latency: each request is checked against 1+WAIT_CYCLES edges per target.
// Backpressure: the bench releases the request only after both targets show ready.
module tb_mem_bus_responder;

    logic       clk;
    logic       reset;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] port_in;
    logic [7:0] port_out1, port_out3;
    logic       perr1, perr3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_bus_responder_if bus1 ();
    mem_bus_responder_if bus3 ();

    assign bus1.address = cpu_addr;
    assign bus1.data_in = cpu_wdata;
    assign bus1.read    = cpu_rd;
    assign bus1.write   = cpu_wr;
    assign bus3.address = cpu_addr;
    assign bus3.data_in = cpu_wdata;
    assign bus3.read    = cpu_rd;
    assign bus3.write   = cpu_wr;

    mem_bus_responder #(.WAIT_CYCLES(1), .IO_BASE(8'hF0)) u_w1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .port_in(port_in), .port_out(port_out1), .proto_err(perr1)
    );

    mem_bus_responder #(.WAIT_CYCLES(3), .IO_BASE(8'hF0)) u_w3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .port_in(port_in), .port_out(port_out3), .proto_err(perr3)
    );

    logic       rdy_a  [2];
    logic [7:0] dout_a [2];
    logic [7:0] pout_a [2];
    logic       perr_a [2];
    assign rdy_a[0]  = bus1.ready;
    assign rdy_a[1]  = bus3.ready;
    assign dout_a[0] = bus1.data_out;
    assign dout_a[1] = bus3.data_out;
    assign pout_a[0] = port_out1;
    assign pout_a[1] = port_out3;
    assign perr_a[0] = perr1;
    assign perr_a[1] = perr3;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model, one entry per target (index 0: 1 wait state, 1: 3 wait states).
    logic [7:0] ram_m   [2][256];
    bit         known   [256];
    logic [7:0] pout_m  [2];
    logic [7:0] last_rd [2];
    logic       perr_m  [2];
    logic [7:0] tm_base [2];   // timer value right after edge tm_edge
    int         tm_edge [2];

    function automatic int wait_of(input int w);
        return (w == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input int w, input logic [7:0] a, input int n);
        if (a < 8'hF0) return ram_m[w][a];
        case (a)
            8'hF0:   return pout_m[w];
            8'hF1:   return port_in;
            8'hF2:   return tm_base[w] + 8'(n - 1 - tm_edge[w]);
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("%s_dout_w%0d", tag, wait_of(w)), dout_a[w], last_rd[w]);
            chk($sformatf("%s_pout_w%0d", tag, wait_of(w)), pout_a[w], pout_m[w]);
            chk($sformatf("%s_perr_w%0d", tag, wait_of(w)), 8'(perr_a[w]), 8'(perr_m[w]));
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int w = 0; w < 2; w++) begin
            tm_base[w] = 8'h00;
            tm_edge[w] = cyc;
            pout_m[w]  = 8'h00;
            perr_m[w]  = 1'b0;
            last_rd[w] = 8'h00;
            chk($sformatf("rst_ready_w%0d", wait_of(w)), 8'(rdy_a[w]), 8'h00);
        end
        check_regs("rst");
    endtask

    // Called #1 after an edge with both targets idle; accepted on the next edge.
    task automatic txn(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input string tag);
        int n;
        logic [7:0] e;
        cpu_addr = a; cpu_wdata = d; cpu_rd = rd; cpu_wr = wr;
        @(posedge clk); #1;
        n = cyc;
        // Bus contents after acceptance must not matter.
        cpu_addr = ~a; cpu_wdata = ~d;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            for (int w = 0; w < 2; w++)
                chk($sformatf("%s_ready_w%0d_e%0d", tag, wait_of(w), k),
                    8'(rdy_a[w]), 8'(k >= 1 + wait_of(w)));
        end
        for (int w = 0; w < 2; w++) begin
            if (rd) begin
                e = model_rd(w, a, n);
                last_rd[w] = e;
            end else if (a < 8'hF0) begin
                ram_m[w][a] = d;
            end else if (a == 8'hF0) begin
                pout_m[w] = d;
            end else if (a == 8'hF2) begin
                tm_base[w] = d;
                tm_edge[w] = n + 1 + wait_of(w);
            end
            if (rd && wr) perr_m[w] = 1'b1;
        end
        check_regs(tag);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        @(posedge clk); #1;
        for (int w = 0; w < 2; w++)
            chk($sformatf("%s_rdyfall_w%0d", tag, wait_of(w)), 8'(rdy_a[w]), 8'h00);
    endtask

    initial begin
        logic [7:0] a, d;
        int         op;
        reset = 1'b1; cpu_addr = 8'h00; cpu_wdata = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0;
        port_in = 8'h00;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;

        do_reset(2);

        // port_out made nonzero, then cleared by reset
        txn(0, 1, 8'hF0, 8'hC3, "pout_pre");
        do_reset(1);

        // RAM write/read, back to back at the earliest acceptance
        txn(0, 1, 8'h10, 8'h5A, "wr10");
        txn(1, 0, 8'h10, 8'h00, "rd10");
        txn(0, 1, 8'hEF, 8'h3C, "wrEF");
        txn(1, 0, 8'hEF, 8'h00, "rdEF");

        // I/O ports
        txn(0, 1, 8'hF0, 8'hC3, "wrF0");
        txn(1, 0, 8'hF0, 8'h00, "rdF0");
        port_in = 8'h7E;
        txn(1, 0, 8'hF1, 8'h00, "rdF1");
        txn(0, 1, 8'hF1, 8'hAA, "wrF1");
        txn(1, 0, 8'hF1, 8'h00, "rdF1b");

        // timer: free-running, then load near the wrap point
        txn(1, 0, 8'hF2, 8'h00, "tmr0");
        txn(0, 1, 8'hF2, 8'hFE, "tmrwr");
        txn(1, 0, 8'hF2, 8'h00, "tmrwrap");
        txn(1, 0, 8'hF5, 8'h00, "rdF5");
        txn(0, 1, 8'hF5, 8'h12, "wrF5");
        txn(1, 0, 8'hFF, 8'h00, "rdFF");

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            d  = 8'($urandom);
            case (op)
                0: begin a = 8'($urandom_range(0, 15)); txn(0, 1, a, d, "r_wram"); known[a] = 1'b1; end
                1: begin
                    a = 8'($urandom_range(0, 15));
                    if (known[a]) txn(1, 0, a, 8'h00, "r_rram");
                    else begin txn(0, 1, a, d, "r_wram"); known[a] = 1'b1; end
                end
                2: txn(0, 1, 8'hF0, d, "r_wpout");
                3: txn(1, 0, 8'hF0, 8'h00, "r_rpout");
                4: begin port_in = d; txn(1, 0, 8'hF1, 8'h00, "r_rpin"); end
                5: txn(1, 0, 8'hF2, 8'h00, "r_rtmr");
                6: txn(0, 1, 8'hF2, d, "r_wtmr");
                default: txn(1, 0, 8'($urandom_range(8'hF3, 8'hFF)), 8'h00, "r_runmap");
            endcase
        end

        // read and write together: serviced as a read, sticky error
        txn(1, 1, 8'h10, 8'h99, "both");
        txn(1, 0, 8'h10, 8'h00, "both_after");

        // reset while the 3-wait-state target is still waiting on a store
        txn(0, 1, 8'h20, 8'h11, "wr20_prior");
        cpu_addr = 8'h20; cpu_wdata = 8'h99; cpu_wr = 1'b1;
        @(posedge clk); #1;                     // accepted
        @(posedge clk); #1;
        chk("abort_e1_ready_w1", 8'(rdy_a[0]), 8'h00);
        chk("abort_e1_ready_w3", 8'(rdy_a[1]), 8'h00);
        @(posedge clk); #1;                     // 1-wait target committed here
        chk("abort_e2_ready_w1", 8'(rdy_a[0]), 8'h01);
        chk("abort_e2_ready_w3", 8'(rdy_a[1]), 8'h00);
        cpu_wr = 1'b0;
        ram_m[0][8'h20] = 8'h99;
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_idle%0d_ready_w3", k), 8'(rdy_a[1]), 8'h00);
        end
        txn(1, 0, 8'h20, 8'h00, "rd20_after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
